// File: rtl/core_refill_arb.sv
// Round-robin arbiter sharing one memory bus between I-side and D-side line bursts.
// One owner holds the bus for BEATS beats, then gets a one-cycle DONE and a one-cycle re-request mask.
module core_refill_arb #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int BEATS  = 4,
    localparam int IDX_W  = $clog2(BEATS)
) (
    input  logic              SYSCLK,
    input  logic              RESET_D1_R,
    input  logic              ARB_HOLD,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_BEAT_VAL,
    output logic              I_DONE,
    input  logic              D_REQ,
    input  logic              D_WR,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_BEAT_VAL,
    output logic              D_DONE,
    output logic              MEM_REQ,
    output logic              MEM_WR,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic [IDX_W-1:0]  BEAT_IDX,
    output logic [1:0]        DBG_STATE
);

    localparam int               BYTE_SHIFT = $clog2(DATA_W / 8);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner_d;     // 1: D-side owns the current/last burst
    logic              last_gnt_d;  // 1: D-side won the most recent grant
    logic              dir_wr;
    logic              mask_vld;    // first IDLE cycle after DONE: owner_d side is masked
    logic [ADDR_W-1:0] base_addr;
    logic [IDX_W-1:0]  beat_idx;

    logic              i_req_eff;
    logic              d_req_eff;
    logic              grant;
    logic              grant_d;
    logic              beat_ack;
    logic              last_beat;
    logic              in_burst;
    logic [ADDR_W-1:0] beat_off;

    always_comb begin
        i_req_eff = I_REQ & ~(mask_vld & ~owner_d);
        d_req_eff = D_REQ & ~(mask_vld & owner_d);
        grant     = (state == IDLE) & ~ARB_HOLD & (i_req_eff | d_req_eff);
        // On a tie the side that did not win last time takes the bus.
        grant_d   = d_req_eff & (~i_req_eff | ~last_gnt_d);
        in_burst  = (state == BURST);
        beat_ack  = in_burst & MEM_ACK;
        last_beat = (beat_idx == LAST_IDX);
        beat_off  = ADDR_W'(beat_idx) << BYTE_SHIFT;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant) state_nxt = BURST;
            BURST:   if (beat_ack && last_beat) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET_D1_R) begin
            state      <= IDLE;
            owner_d    <= 1'b0;
            last_gnt_d <= 1'b0;
            dir_wr     <= 1'b0;
            mask_vld   <= 1'b0;
            base_addr  <= '0;
            beat_idx   <= '0;
        end else begin
            state    <= state_nxt;
            mask_vld <= (state == DONE);
            if (grant) begin
                owner_d    <= grant_d;
                last_gnt_d <= grant_d;
                base_addr  <= grant_d ? D_ADDR : I_ADDR;
                dir_wr     <= grant_d & D_WR;
                beat_idx   <= '0;
            end else if (beat_ack) begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
        end
    end

    // Bus handshake: MEM_REQ stays high for the whole burst; a beat transfers in any
    // cycle where MEM_REQ and MEM_ACK are both high, and nothing advances otherwise.
    always_comb begin
        MEM_REQ    = in_burst;
        MEM_WR     = in_burst & dir_wr;
        MEM_ADDR   = in_burst ? (base_addr + beat_off) : '0;
        MEM_WDATA  = (in_burst & dir_wr) ? D_WDATA : '0;
        RDATA      = MEM_RDATA;
        I_BEAT_VAL = beat_ack & ~owner_d;
        D_BEAT_VAL = beat_ack & owner_d;
        I_DONE     = (state == DONE) & ~owner_d;
        D_DONE     = (state == DONE) & owner_d;
        BEAT_IDX   = beat_idx;
        DBG_STATE  = state;
    end

    assert property (@(posedge SYSCLK) disable iff (RESET_D1_R)
        state inside {IDLE, BURST, DONE});
    assert property (@(posedge SYSCLK) disable iff (RESET_D1_R)
        (state == DONE) |=> (state == IDLE));

endmodule
